// File: rtl/smi_flit_scale_u4.sv
// Packs narrow SMI flits (FlitWidth/4 bytes) into FlitWidth-byte flits.
// A frame end closes the current wide flit early; FlitWidth must be a power of two, 4..128.
module smi_flit_scale_u4 #(
  parameter int unsigned FlitWidth = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   smiInReady,
  input  logic [7:0]             smiInEofc,
  input  logic [FlitWidth*2-1:0] smiInData,
  output logic                   smiInStop,
  output logic                   smiOutReady,
  output logic [7:0]             smiOutEofc,
  output logic [FlitWidth*8-1:0] smiOutData,
  input  logic                   smiOutStop
);

  localparam int unsigned IW    = FlitWidth / 4;
  localparam int unsigned SlotW = IW * 8;
  localparam int unsigned OutW  = FlitWidth * 8;

  logic [1:0]            slot, slotNxt;
  logic [2:0][SlotW-1:0] acc, accNxt;
  logic                  outValid, outValidNxt;
  logic [7:0]            outEofc, outEofcNxt;
  logic [OutW-1:0]       outData, outDataNxt;

  logic                  inFire;
  logic                  outFire;
  logic                  closeFlit;
  logic [7:0]            eofcClamp;
  logic [OutW-1:0]       wideData;
  logic [7:0]            wideEofc;

  // The whole accumulator stalls only while a full output register is held off.
  assign smiInStop   = outValid & smiOutStop;
  assign inFire      = smiInReady & ~smiInStop;
  assign outFire     = outValid & ~smiOutStop;
  assign closeFlit   = inFire & ((slot == 2'd3) | (smiInEofc != 8'd0));
  assign eofcClamp   = (smiInEofc > 8'(IW)) ? 8'(IW) : smiInEofc;

  assign smiOutReady = outValid;
  assign smiOutEofc  = outEofc;
  assign smiOutData  = outData;

  // Wide flit: stored slots below `slot`, live input at `slot`, zeros above the last valid byte.
  always_comb begin
    wideData = '0;
    for (int k = 0; k < 3; k++) begin
      if (2'(k) < slot) begin
        wideData[k*SlotW +: SlotW] = acc[k];
      end
    end
    for (int k = 0; k < 4; k++) begin
      for (int b = 0; b < IW; b++) begin
        if ((2'(k) == slot) && ((smiInEofc == 8'd0) || (8'(b) < eofcClamp))) begin
          wideData[k*SlotW + b*8 +: 8] = smiInData[b*8 +: 8];
        end
      end
    end
    wideEofc = (smiInEofc == 8'd0) ? 8'd0 : 8'(8'(slot) * 8'(IW) + eofcClamp);
  end

  // Next-state: a reload on the same edge as a drain keeps outValid high.
  always_comb begin
    slotNxt     = slot;
    accNxt      = acc;
    outValidNxt = outValid;
    outEofcNxt  = outEofc;
    outDataNxt  = outData;
    if (outFire) begin
      outValidNxt = 1'b0;
    end
    if (closeFlit) begin
      outValidNxt = 1'b1;
      outDataNxt  = wideData;
      outEofcNxt  = wideEofc;
      slotNxt     = 2'd0;
    end else if (inFire) begin
      for (int k = 0; k < 3; k++) begin
        if (2'(k) == slot) begin
          accNxt[k] = smiInData;
        end
      end
      slotNxt = slot + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot     <= 2'd0;
      acc      <= '0;
      outValid <= 1'b0;
      outEofc  <= 8'd0;
      outData  <= '0;
    end else begin
      slot     <= slotNxt;
      acc      <= accNxt;
      outValid <= outValidNxt;
      outEofc  <= outEofcNxt;
      outData  <= outDataNxt;
    end
  end

endmodule
